// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store byte sequencer: access sizes, FSM states
// and the size-to-byte-count helper.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Illegal size never reaches ACCESS, so its count is irrelevant.
  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      SZ_B:    byte_count = 3'd1;
      SZ_H:    byte_count = 3'd2;
      SZ_W:    byte_count = 3'd4;
      default: byte_count = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Assembles the little-endian load register into a 32-bit result,
// sign- or zero-extending byte and half loads.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] ext_data
);

  always_comb begin
    ext_data = data;
    case (size)
      SZ_B:    ext_data = {{24{~uns & data[7]}}, data[7:0]};
      SZ_H:    ext_data = {{16{~uns & data[15]}}, data[15:0]};
      default: ext_data = data;
    endcase
  end

endmodule

// File: rtl/lsu_byte_sequencer.sv
// Splits one RV32 load/store into byte accesses on the 8-bit dram port.
// LSU_MISALIGN_SPLIT_EN: misaligned half/word requests are split instead of rejected.
//
// state  | meaning
// IDLE   | ready; accepts a request on any edge with req_valid
// ACCESS | one dram byte per cycle, idx = 0..N-1
// RESP   | single-cycle response pulse, then back to IDLE
module lsu_byte_sequencer
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_mw,
  input  logic [7:0]        mem_rdata
);

  state_t      state;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        we_q;
  logic        err_q;
  logic [31:0] wdata_q;
  logic [31:0] data_q;
  logic [1:0]  idx;
  logic [1:0]  idx_nxt;
  logic        last;
  logic        req_bad;
  logic [31:0] ext_data;

`ifdef LSU_MISALIGN_SPLIT_EN
  assign req_bad = (req_size == 2'b11);
`else
  logic misalign;
  assign misalign = ((req_size == SZ_H) && req_addr[0]) ||
                    ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
  assign req_bad  = (req_size == 2'b11) || misalign;
`endif

  assign idx_nxt = idx + 2'd1;
  assign last    = (idx == 2'(byte_count(size_q) - 3'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      size_q    <= SZ_B;
      uns_q     <= 1'b0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      wdata_q   <= '0;
      data_q    <= '0;
      idx       <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            we_q    <= req_we;
            wdata_q <= req_wdata;
            err_q   <= req_bad;
            data_q  <= '0;
            idx     <= '0;
            if (req_bad) begin
              state <= RESP;
            end else begin
              state    <= ACCESS;
              mem_addr <= req_addr;
              if (req_we) mem_wdata <= req_wdata[7:0];
            end
          end
        end
        ACCESS: begin
          if (!we_q) data_q[{idx, 3'b000} +: 8] <= mem_rdata;
          if (last) begin
            state <= RESP;
          end else begin
            idx      <= idx_nxt;
            mem_addr <= mem_addr + ADDR_W'(1);
            if (we_q) mem_wdata <= wdata_q[{idx_nxt, 3'b000} +: 8];
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  lsu_load_extend u_load_extend (
    .data     (data_q),
    .size     (size_q),
    .uns      (uns_q),
    .ext_data (ext_data)
  );

  // Write enable depends on registered state only so reset kills it immediately.
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_err   = resp_valid & err_q;
  assign mem_mw     = (state == ACCESS) & we_q;
  assign resp_rdata = (resp_valid && !we_q && !err_q) ? ext_data : '0;

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// Directed bench for lsu_byte_sequencer with a byte-wide dram model and a
// response scoreboard.
module tb_lsu_byte_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [9:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_mw;
  logic [7:0]  mem_rdata;

  always #5 clk = ~clk;

  lsu_byte_sequencer #(.ADDR_W(10)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_mw       (mem_mw),
    .mem_rdata    (mem_rdata)
  );

  logic [7:0] mem [0:1023];
  initial for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_mw) mem[mem_addr] <= mem_wdata;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int w = 0;
    @(negedge clk);
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic txn(input string tag, input logic we, input logic [1:0] size,
                     input logic uns, input logic [9:0] addr, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err);
    int   n;
    logic got;
    exp_t e;
    exp_t a;
    logic [9:0] ea;
    n       = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.lat   = exp_err ? 1 : n + 1;
    wait_ready(tag);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    sb.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wdata = 32'h5A5A5A5A;
    req_addr  = 10'h155;
    got = 1'b0;
    for (int k = 1; k <= 8 && !got; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      if (resp_valid) begin
        got = 1'b1;
        chk({tag, ".sb_depth"}, sb.size(), 32'd1);
        if (sb.size() > 0) begin
          a = sb.pop_front();
          chk({tag, ".rdata"}, resp_rdata, a.rdata);
          chk({tag, ".err"}, {31'd0, resp_err}, {31'd0, a.err});
          chk({tag, ".latency"}, k, a.lat);
        end
      end else if (we && !exp_err && k <= n) begin
        ea = addr + 10'(k - 1);
        chk({tag, ".mw"}, {31'd0, mem_mw}, 32'd1);
        chk({tag, ".maddr"}, {22'd0, mem_addr}, {22'd0, ea});
        chk({tag, ".mwdata"}, {24'd0, mem_wdata}, {24'd0, wd[8*(k-1) +: 8]});
      end else begin
        chk({tag, ".mw_low"}, {31'd0, mem_mw}, 32'd0);
      end
    end
    chk({tag, ".got_resp"}, {31'd0, got}, 32'd1);
  endtask

  initial begin
    #3;
    chk("rst.ready", {31'd0, req_ready}, 32'd1);
    chk("rst.rvalid", {31'd0, resp_valid}, 32'd0);
    chk("rst.err", {31'd0, resp_err}, 32'd0);
    chk("rst.rdata", resp_rdata, 32'd0);
    chk("rst.mw", {31'd0, mem_mw}, 32'd0);
    chk("rst.maddr", {22'd0, mem_addr}, 32'd0);
    chk("rst.mwdata", {24'd0, mem_wdata}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    txn("sw4",   1'b1, 2'b10, 1'b0, 10'h004, 32'hDEADBEEF, 32'h00000000, 1'b0);
    txn("lw4",   1'b0, 2'b10, 1'b0, 10'h004, 32'h0,        32'hDEADBEEF, 1'b0);
    txn("lb7",   1'b0, 2'b00, 1'b0, 10'h007, 32'h0,        32'hFFFFFFDE, 1'b0);
    txn("lbu7",  1'b0, 2'b00, 1'b1, 10'h007, 32'h0,        32'h000000DE, 1'b0);
    txn("lh6",   1'b0, 2'b01, 1'b0, 10'h006, 32'h0,        32'hFFFFDEAD, 1'b0);
    txn("lhu6",  1'b0, 2'b01, 1'b1, 10'h006, 32'h0,        32'h0000DEAD, 1'b0);
    txn("sb10",  1'b1, 2'b00, 1'b0, 10'h010, 32'hFFFFFF55, 32'h00000000, 1'b0);
    txn("lbu10", 1'b0, 2'b00, 1'b1, 10'h010, 32'h0,        32'h00000055, 1'b0);
    txn("lw10",  1'b0, 2'b10, 1'b0, 10'h010, 32'h0,        32'h00000055, 1'b0);
    txn("sh12",  1'b1, 2'b01, 1'b0, 10'h012, 32'h12348001, 32'h00000000, 1'b0);
    txn("lh12",  1'b0, 2'b01, 1'b0, 10'h012, 32'h0,        32'hFFFF8001, 1'b0);
    txn("lb4",   1'b0, 2'b00, 1'b0, 10'h004, 32'h0,        32'hFFFFFFEF, 1'b0);
    txn("sill",  1'b1, 2'b11, 1'b0, 10'h020, 32'hCAFEF00D, 32'h00000000, 1'b1);
    chk("sill.mem20", {24'd0, mem[10'h020]}, 32'd0);
`ifdef LSU_MISALIGN_SPLIT_EN
    txn("lh5",   1'b0, 2'b01, 1'b0, 10'h005, 32'h0,        32'hFFFFADBE, 1'b0);
    txn("sw3fe", 1'b1, 2'b10, 1'b0, 10'h3FE, 32'h11223344, 32'h00000000, 1'b0);
    chk("wrap.m3fe", {24'd0, mem[10'h3FE]}, 32'h44);
    chk("wrap.m3ff", {24'd0, mem[10'h3FF]}, 32'h33);
    chk("wrap.m000", {24'd0, mem[10'h000]}, 32'h22);
    chk("wrap.m001", {24'd0, mem[10'h001]}, 32'h11);
    txn("lw3fe", 1'b0, 2'b10, 1'b0, 10'h3FE, 32'h0,        32'h11223344, 1'b0);
`else
    txn("lh5",   1'b0, 2'b01, 1'b0, 10'h005, 32'h0,        32'h00000000, 1'b1);
    txn("sw6",   1'b1, 2'b10, 1'b0, 10'h006, 32'h99999999, 32'h00000000, 1'b1);
    chk("sw6.mem6", {24'd0, mem[10'h006]}, 32'hAD);
`endif

    // Store interrupted by reset during its third byte.
    wait_ready("rstmid");
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'b10;
    req_addr  = 10'h008;
    req_wdata = 32'hAABBCCDD;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("rstmid.mw_pre", {31'd0, mem_mw}, 32'd1);
    chk("rstmid.maddr_pre", {22'd0, mem_addr}, 32'h00A);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid.mw", {31'd0, mem_mw}, 32'd0);
    chk("rstmid.ready", {31'd0, req_ready}, 32'd1);
    chk("rstmid.rvalid", {31'd0, resp_valid}, 32'd0);
    chk("rstmid.maddr", {22'd0, mem_addr}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("rstmid.no_resp", {31'd0, resp_valid}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    chk("rstmid.m008", {24'd0, mem[10'h008]}, 32'hDD);
    chk("rstmid.m009", {24'd0, mem[10'h009]}, 32'hCC);
    chk("rstmid.m00a", {24'd0, mem[10'h00A]}, 32'h00);
    txn("lw8",   1'b0, 2'b10, 1'b0, 10'h008, 32'h0,        32'h0000CCDD, 1'b0);

    // Back-to-back illegal requests: error pulse every other cycle.
    wait_ready("b2b");
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_size  = 2'b11;
    req_addr  = 10'h000;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      chk("b2b.rvalid", {31'd0, resp_valid}, 32'(k % 2));
      chk("b2b.err", {31'd0, resp_err}, 32'(k % 2));
      chk("b2b.ready", {31'd0, req_ready}, 32'(1 - (k % 2)));
      chk("b2b.rdata", resp_rdata, 32'd0);
    end
    req_valid = 1'b0;
    @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/lsu_byte_sequencer.md
Name: lsu_byte_sequencer

Overview:
Load/store sequencer directly upstream of the byte-wide data memory (dram). Accepts one RV32 load/store request (byte/half/word, signed/unsigned) from the execute stage. Breaks it into little-endian byte accesses on the memory's 8-bit port, one per cycle. For loads it assembles and sign/zero-extends the result and returns a single-cycle response.

Parameters:
ADDR_W, 10, byte-address width; matches the dram address port.

Ports:
CLK  input  1  system clock, rising edge.
RST_N  input  1  asynchronous active-low reset.
REQ_VALID  input  1  request present.
REQ_READY  output  1  sequencer can accept a request; high only in IDLE.
REQ_WE  input  1  1 = store, 0 = load.
REQ_SIZE  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ_UNSIGNED  input  1  load zero-extends when 1; ignored for stores.
REQ_ADDR  input  ADDR_W  byte address.
REQ_WDATA  input  32  store data, low bytes used per size.
RESP_VALID  output  1  one-cycle pulse: request finished.
RESP_RDATA  output  32  extended load data; 0 for stores and errors.
RESP_ERR  output  1  valid with RESP_VALID; misaligned or illegal size.
MEM_ADDR  output  ADDR_W  byte address to dram.
MEM_WDATA  output  8  byte to write.
MEM_MW  output  1  dram write enable.
MEM_RDATA  input  8  dram byte read data; combinational from MEM_ADDR, sampled at the CLK rising edge.

Behaviour:
- Reset (async, RST_N=0): state IDLE, byte index 0, data register 0.
  - Outputs: REQ_READY=1, RESP_VALID=0, RESP_ERR=0, RESP_RDATA=0, MEM_MW=0, MEM_ADDR=0, MEM_WDATA=0.
  - MEM_MW is decoded from registered state only, so it drops the instant RST_N falls.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - Request accepted on an edge where REQ_VALID=1; REQ_READY=1 only in IDLE.
  - The edge latches address, size, unsigned flag, write-enable and data.
  - Byte count N: 1, 2 or 4 by size.
  - Misaligned request (half with addr[0]=1; word with addr[1:0]≠0) or size 11 goes IDLE→RESP, with no MEM_MW assertion.
  - Otherwise IDLE→ACCESS.
- ACCESS, index i = 0..N-1, one cycle each:
  - MEM_ADDR = base+i, modulo 2^ADDR_W.
  - Store: MEM_MW=1, MEM_WDATA = REQ_WDATA[8i+7:8i].
  - Load: MEM_MW=0; MEM_RDATA is captured into byte i at the edge ending the cycle.
  - The edge after i=N-1 goes to RESP.
- RESP, exactly one cycle:
  - RESP_VALID=1, then return to IDLE. No backpressure.
  - Load: RESP_RDATA = assembled bytes, sign-extended from bit 8N-1 unless unsigned; word is passed through.
  - Store or error: RESP_RDATA=0.
  - RESP_ERR=1 only on the error path.
- Latency from the accept edge: RESP_VALID in cycle N+1; error responses in cycle 1.
- Throughput: a new request is accepted in the IDLE cycle after RESP; min period N+2 cycles.
- Outside ACCESS: MEM_MW=0, and MEM_ADDR/MEM_WDATA hold their last value.
- Reset mid-operation: transaction abandoned, bytes already written remain, no RESP issued.
- REQ_* inputs are ignored outside IDLE.

Optional Feature:
LSU_MISALIGN_SPLIT_EN
- Defined: misaligned half/word requests are not errors. They go through ACCESS byte by byte; addresses wrap modulo 2^ADDR_W (e.g. 0x3FF+1 → 0x000). Size 11 remains an error.
- Undefined: misaligned requests produce RESP_ERR=1 as above.

Decomposition:
- Package lsu_pkg holds:
  - size encodings: SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10;
  - the state encoding: IDLE, ACCESS, RESP;
  - a function returning byte count from size.
- One sub-module, lsu_load_extend: combinational 32-bit assemble/extend from data register, size and unsigned flag. It is instantiated once and kept separate for unit test.

Test Plan:
- SW 0xDEADBEEF @0x004: cycles 1-4 show MEM_MW=1, MEM_ADDR 0x004..0x007, MEM_WDATA EF,BE,AD,DE; RESP_VALID in cycle 5, RESP_ERR=0, RESP_RDATA=0.
- LW @0x004 after the above: RESP_RDATA=0xDEADBEEF in cycle 5; MEM_MW stays 0 throughout.
- LB @0x007 → 0xFFFFFFDE; LBU @0x007 → 0x000000DE; LH @0x006 → 0xFFFFDEAD; LHU @0x006 → 0x0000DEAD; each RESP in cycle 2 or 3.
- LH @0x005, macro undefined: RESP_VALID+RESP_ERR in cycle 1, no MEM_MW. Macro defined: SW 0x11223344 @0x3FE writes 0x3FE=44, 0x3FF=33, 0x000=22, 0x001=11, and LW @0x3FE returns 0x11223344.
- SW 0xAABBCCDD @0x008 with RST_N pulled low mid-cycle 3: MEM_MW falls immediately, REQ_READY=1, no RESP_VALID. A later LW @0x008 returns 0x????CCDD: bytes 0x00A/0x00B unchanged.
- REQ_VALID held high back-to-back with REQ_SIZE=11: RESP_ERR pulses every 2 cycles, REQ_READY low in RESP cycles.
